sccb_slave: RTL and testbench

- SCCB responder (camera-side target) for the existing SCCB master.
- Decodes 3-phase write, 2-phase write (sub-address set) and 2-phase read transactions on scl/sda.
- Exposes an 8-bit register-bank access port.
- Used as the camera model in simulation and for FPGA loopback of the DCMI/SCCB path.
- Oversamples scl/sda on the system clock; does not run on scl.

---
 rtl/sccb_pkg.sv | 21 ++
 rtl/sccb_line_detect.sv | 45 ++++
 rtl/sccb_slave.sv | 198 +++++++++++++++++++
 tb/tb_sccb_slave.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: bus widths, default camera ID and the target FSM state encoding.
package sccb_pkg;

   localparam int unsigned SCCB_DATA_WIDTH     = 8;
   localparam int unsigned SCCB_ADDR_WIDTH     = 8;
   localparam logic [6:0]  SCCB_DEVICE_ADDRESS = 7'h42;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_DEV_ID   = 4'd1,
      S_DEV_ACK  = 4'd2,
      S_SUB_ADDR = 4'd3,
      S_SUB_ACK  = 4'd4,
      S_WR_DATA  = 4'd5,
      S_WR_ACK   = 4'd6,
      S_RD_DATA  = 4'd7,
      S_RD_ACK   = 4'd8,
      S_IGNORE   = 4'd9
   } sccb_state_e;

endpackage

// File: rtl/sccb_line_detect.sv
// Two-flop synchronizers for scl/sda plus single-cycle edge, START and STOP pulses.
module sccb_line_detect (
   input  logic clk,
   input  logic rstn,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_c_o,
   output logic scl_fall_c_o,
   output logic start_c_o,
   output logic stop_c_o
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_prev_q;
   logic       sda_prev_q;
   logic       scl_s;
   logic       sda_s;

   // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
      end
   end

   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];

   assign sda_o        = sda_s;
   assign scl_rise_c_o = scl_s & ~scl_prev_q;
   assign scl_fall_c_o = ~scl_s & scl_prev_q;
   assign start_c_o    = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
   assign stop_c_o     = scl_s & scl_prev_q & sda_s & ~sda_prev_q;

endmodule

// File: rtl/sccb_slave.sv
// SCCB camera-side target: decodes 3-phase write, 2-phase write and 2-phase read on an
// oversampled scl/sda pair and drives an 8-bit register-bank access port.
module sccb_slave
   import sccb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = SCCB_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH     = SCCB_ADDR_WIDTH,
   parameter logic [6:0]  DEVICE_ADDRESS = SCCB_DEVICE_ADDRESS
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  scl,
   inout  wire                   sda,
   output logic                  reg_wr,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   output logic                  busy
);

   localparam int unsigned        CNT_W     = 4;
   localparam logic [CNT_W-1:0]   BYTE_BITS = CNT_W'(8);

   sccb_state_e           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [7:0]            shift_q, shift_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  wr_q, wr_d;
   logic                  busy_q, busy_d;
   logic                  oe_q, oe_d;
   logic                  rw_q, rw_d;

   logic       sda_s;
   logic       scl_rise_c;
   logic       scl_fall_c;
   logic       start_c;
   logic       stop_c;
   logic [7:0] rdata_byte;

   sccb_line_detect u_line_detect (
      .clk          (clk),
      .rstn         (rstn),
      .scl_i        (scl),
      .sda_i        (sda),
      .sda_o        (sda_s),
      .scl_rise_c_o (scl_rise_c),
      .scl_fall_c_o (scl_fall_c),
      .start_c_o    (start_c),
      .stop_c_o     (stop_c)
   );

   // Open-drain: only ever pull low or release.
   assign sda        = oe_q ? 1'b0 : 1'bz;
   assign rdata_byte = 8'(reg_rdata);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         oe_q    <= 1'b0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         oe_q    <= oe_d;
         rw_q    <= rw_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = 1'b0;
      busy_d  = busy_q;
      oe_d    = oe_q;
      rw_d    = rw_q;

      if (start_c) begin
         state_d = S_DEV_ID;
         cnt_d   = '0;
         oe_d    = 1'b0;
         busy_d  = 1'b1;
      end else if (stop_c) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_DEV_ID, S_SUB_ADDR, S_WR_DATA: begin
               if (scl_rise_c) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + CNT_W'(1);
               end else if (scl_fall_c && cnt_q == BYTE_BITS) begin
                  cnt_d = '0;
                  if (state_q == S_DEV_ID) begin
                     if (shift_q[7:1] == DEVICE_ADDRESS) begin
                        state_d = S_DEV_ACK;
                        oe_d    = 1'b1;
                        rw_d    = shift_q[0];
                     end else begin
                        state_d = S_IGNORE;
                     end
                  end else if (state_q == S_SUB_ADDR) begin
                     addr_d  = ADDR_WIDTH'(shift_q);
                     oe_d    = 1'b1;
                     state_d = S_SUB_ACK;
                  end else begin
                     wdata_d = DATA_WIDTH'(shift_q);
                     wr_d    = 1'b1;
                     oe_d    = 1'b1;
                     state_d = S_WR_ACK;
                  end
               end
            end
            S_DEV_ACK: begin
               if (scl_fall_c) begin
                  cnt_d = '0;
                  if (rw_q) begin
                     state_d = S_RD_DATA;
                     shift_d = rdata_byte;
                     oe_d    = ~rdata_byte[7];
                  end else begin
                     state_d = S_SUB_ADDR;
                     oe_d    = 1'b0;
                  end
               end
            end
            S_SUB_ACK: begin
               if (scl_fall_c) begin
                  oe_d    = 1'b0;
                  state_d = S_WR_DATA;
               end
            end
            S_WR_ACK: begin
               if (scl_fall_c) begin
                  oe_d    = 1'b0;
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  state_d = S_WR_DATA;
               end
            end
            S_RD_DATA: begin
               if (scl_rise_c) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (scl_fall_c) begin
                  if (cnt_q == BYTE_BITS) begin
                     oe_d    = 1'b0;
                     cnt_d   = '0;
                     state_d = S_RD_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     oe_d    = ~shift_q[6];
                  end
               end
            end
            S_RD_ACK: begin
               // cnt_q == 1 marks a master ACK seen; next byte loads on the following fall.
               if (scl_rise_c) begin
                  if (!sda_s) begin
                     addr_d = addr_q + ADDR_WIDTH'(1);
                     cnt_d  = CNT_W'(1);
                  end else begin
                     oe_d    = 1'b0;
                     state_d = S_IGNORE;
                  end
               end else if (scl_fall_c && cnt_q == CNT_W'(1)) begin
                  cnt_d   = '0;
                  shift_d = rdata_byte;
                  oe_d    = ~rdata_byte[7];
                  state_d = S_RD_DATA;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign reg_wr    = wr_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: a behavioural SCCB master, a small register bank and a write log.
module tb_sccb_slave;
   import sccb_pkg::*;

   logic       clk;
   logic       rstn;
   logic       scl;
   logic       m_sda_low;
   wire        sda;
   logic       reg_wr;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       busy;

   logic [7:0] bank [256];
   logic [7:0] wr_addr_log [16];
   logic [7:0] wr_data_log [16];
   int         wr_cnt  = 0;
   int         drv_cnt = 0;
   int         n_chk   = 0;
   int         n_fail  = 0;

   sccb_slave u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .scl       (scl),
      .sda       (sda),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   assign sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   assign reg_rdata = bank[reg_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on negedge, so posedge sees settled values.
   always @(posedge clk) begin
      if (reg_wr) begin
         wr_addr_log[wr_cnt[3:0]] <= reg_addr;
         wr_data_log[wr_cnt[3:0]] <= reg_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (!m_sda_low && sda === 1'b0) drv_cnt <= drv_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clk_bit(input logic b, output logic rb);
      wait_clk(4);
      m_sda_low = ~b;
      wait_clk(4);
      scl = 1'b1;
      wait_clk(4);
      rb = sda;
      wait_clk(4);
      scl = 1'b0;
   endtask

   task automatic start_cond();
      m_sda_low = 1'b0;
      wait_clk(4);
      scl = 1'b1;
      wait_clk(4);
      m_sda_low = 1'b1;
      wait_clk(4);
      scl = 1'b0;
   endtask

   task automatic stop_cond();
      wait_clk(4);
      m_sda_low = 1'b1;
      wait_clk(4);
      scl = 1'b1;
      wait_clk(4);
      m_sda_low = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
      clk_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, r);
         d[i] = r;
      end
      clk_bit(mack, r);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a0, a1, a2, a3, r;
      logic [7:0] d0, d1;
      int         wr_base, drv_base;

      for (int i = 0; i < 256; i++) bank[i] = 8'(i) ^ 8'h3C;
      bank[8'h0A] = 8'h77;
      bank[8'h30] = 8'h5A;
      bank[8'h31] = 8'hA5;

      rstn = 1'b0;
      scl = 1'b1;
      m_sda_low = 1'b0;
      wait_clk(5);
      check("rst_reg_wr", 32'(reg_wr), 32'h0);
      check("rst_reg_addr", 32'(reg_addr), 32'h0);
      check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_sda", 32'(sda), 32'h1);
      check("rst_state", 32'(u_dut.state_q), 32'(S_IDLE));
      check("rst_cnt", 32'(u_dut.cnt_q), 32'h0);
      rstn = 1'b1;
      wait_clk(5);

      // 3-phase write 0x84 / 0x12 / 0x80
      wr_base = wr_cnt;
      start_cond();
      check("t1_busy_start", 32'(busy), 32'h1);
      send_byte(8'h84, a0);
      send_byte(8'h12, a1);
      send_byte(8'h80, a2);
      check("t1_ack_id", 32'(a0), 32'h0);
      check("t1_ack_sub", 32'(a1), 32'h0);
      check("t1_ack_data", 32'(a2), 32'h0);
      stop_cond();
      wait_clk(1);
      check("t1_busy_after_stop_1clk", 32'(busy), 32'h1);
      wait_clk(2);
      check("t1_busy_after_stop_3clk", 32'(busy), 32'h0);
      check("t1_wr_count", 32'(wr_cnt - wr_base), 32'd1);
      check("t1_wr_addr", 32'(wr_addr_log[wr_base[3:0]]), 32'h12);
      check("t1_wr_data", 32'(wr_data_log[wr_base[3:0]]), 32'h80);
      wait_clk(4);

      // 2-phase write to 0x0A then read with NACK
      wr_base = wr_cnt;
      start_cond();
      send_byte(8'h84, a0);
      send_byte(8'h0A, a1);
      stop_cond();
      wait_clk(6);
      start_cond();
      send_byte(8'h85, a2);
      read_byte(1'b1, d0);
      stop_cond();
      wait_clk(6);
      check("t2_ack_id_w", 32'(a0), 32'h0);
      check("t2_ack_sub", 32'(a1), 32'h0);
      check("t2_ack_id_r", 32'(a2), 32'h0);
      check("t2_read_byte", 32'(d0), 32'h77);
      check("t2_no_wr", 32'(wr_cnt - wr_base), 32'd0);
      check("t2_reg_addr", 32'(reg_addr), 32'h0A);

      // ID mismatch: 0x42 carries 7-bit ID 0x21
      wr_base = wr_cnt;
      drv_base = drv_cnt;
      start_cond();
      send_byte(8'h42, a0);
      send_byte(8'h55, a1);
      send_byte(8'h66, a2);
      stop_cond();
      wait_clk(6);
      check("t3_no_ack_id", 32'(a0), 32'h1);
      check("t3_no_ack_b2", 32'(a1), 32'h1);
      check("t3_never_driven", 32'(drv_cnt - drv_base), 32'd0);
      check("t3_no_wr", 32'(wr_cnt - wr_base), 32'd0);
      check("t3_busy", 32'(busy), 32'h0);
      check("t3_state", 32'(u_dut.state_q), 32'(S_IDLE));

      // Burst write wrapping 0xFF -> 0x00
      wr_base = wr_cnt;
      start_cond();
      send_byte(8'h84, a0);
      send_byte(8'hFF, a1);
      send_byte(8'h11, a2);
      send_byte(8'h22, a3);
      stop_cond();
      wait_clk(6);
      check("t4_acks", 32'({a0, a1, a2, a3}), 32'h0);
      check("t4_wr_count", 32'(wr_cnt - wr_base), 32'd2);
      check("t4_wr0_addr", 32'(wr_addr_log[wr_base[3:0]]), 32'hFF);
      check("t4_wr0_data", 32'(wr_data_log[wr_base[3:0]]), 32'h11);
      check("t4_wr1_addr", 32'(wr_addr_log[4'(wr_base + 1)]), 32'h00);
      check("t4_wr1_data", 32'(wr_data_log[4'(wr_base + 1)]), 32'h22);
      check("t4_addr_after", 32'(reg_addr), 32'h01);

      // Two-byte read with master ACK after the first byte
      start_cond();
      send_byte(8'h84, a0);
      send_byte(8'h30, a1);
      stop_cond();
      wait_clk(6);
      start_cond();
      send_byte(8'h85, a2);
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      stop_cond();
      wait_clk(6);
      check("t5_acks", 32'({a0, a1, a2}), 32'h0);
      check("t5_byte0", 32'(d0), 32'h5A);
      check("t5_byte1", 32'(d1), 32'hA5);
      check("t5_reg_addr", 32'(reg_addr), 32'h31);

      // STOP after 4 bits of sub-address
      wr_base = wr_cnt;
      start_cond();
      send_byte(8'h84, a0);
      clk_bit(1'b0, r);
      clk_bit(1'b1, r);
      clk_bit(1'b0, r);
      clk_bit(1'b1, r);
      stop_cond();
      wait_clk(6);
      check("t6_state", 32'(u_dut.state_q), 32'(S_IDLE));
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_reg_addr", 32'(reg_addr), 32'h31);
      check("t6_no_wr", 32'(wr_cnt - wr_base), 32'd0);

      // Reset while the target is pulling sda low during a read (0xA5: bit6 = 0)
      start_cond();
      send_byte(8'h85, a0);
      clk_bit(1'b1, r);
      check("t7_first_bit", 32'(r), 32'h1);
      wait_clk(5);
      check("t7_driving_low", 32'(sda), 32'h0);
      check("t7_state_pre", 32'(u_dut.state_q), 32'(S_RD_DATA));
      rstn = 1'b0;
      #1;
      check("t7_sda_released", 32'(sda), 32'h1);
      check("t7_reg_wr", 32'(reg_wr), 32'h0);
      check("t7_reg_addr", 32'(reg_addr), 32'h0);
      check("t7_reg_wdata", 32'(reg_wdata), 32'h0);
      check("t7_busy", 32'(busy), 32'h0);
      check("t7_state", 32'(u_dut.state_q), 32'(S_IDLE));
      check("t7_cnt", 32'(u_dut.cnt_q), 32'h0);
      wait_clk(2);
      scl = 1'b1;
      m_sda_low = 1'b0;
      wait_clk(3);
      rstn = 1'b1;
      wait_clk(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
